// File: rtl/ro_puf_counter.sv
// Ring-oscillator PUF: counts rising edges of two ROs over a fixed window and compares them.
// Latency: start sample to done pulse spans SETTLE_CYCLES + WINDOW_CYCLES + 2 clk edges.
// Backpressure: none; start is honoured only in IDLE and is never queued while busy.
module ro_puf_counter #(
  parameter int CNT_W         = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_enable,
  output logic             ro_reset,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    COUNT   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Timer is loaded with (length - 1) and the phase ends when it reads zero.
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WINDOW_LOAD = 16'(WINDOW_CYCLES - 1);

  state_t           state_q;
  logic [15:0]      timer_q;
  logic             ro_enable_q;
  logic             ro_reset_q;
  logic             busy_q;
  logic             done_q;
  logic             response_q;
  logic             tie_q;
  logic [CNT_W-1:0] count_a_q;
  logic [CNT_W-1:0] count_b_q;
  logic [CNT_W-1:0] count_a_d;
  logic [CNT_W-1:0] count_b_d;

  // The RO outputs are asynchronous: two flops to resolve metastability, a third as edge history.
  logic a_meta_q, a_sync_q, a_hist_q;
  logic b_meta_q, b_sync_q, b_hist_q;
  logic edge_a, edge_b;

  // Synchronize both oscillator outputs and keep one cycle of history for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      a_hist_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
      b_hist_q <= 1'b0;
    end else begin
      a_meta_q <= ro_a;
      a_sync_q <= a_meta_q;
      a_hist_q <= a_sync_q;
      b_meta_q <= ro_b;
      b_sync_q <= b_meta_q;
      b_hist_q <= b_sync_q;
    end
  end

  assign edge_a = a_sync_q & ~a_hist_q;
  assign edge_b = b_sync_q & ~b_hist_q;

  // Saturating increments; each counter stops at all-ones rather than wrapping.
  always_comb begin
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    if (edge_a && (count_a_q != '1)) count_a_d = count_a_q + CNT_W'(1);
    if (edge_b && (count_b_q != '1)) count_b_d = count_b_q + CNT_W'(1);
  end

  // Measurement sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      ro_enable_q <= 1'b0;
      ro_reset_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      response_q  <= 1'b0;
      tie_q       <= 1'b0;
      count_a_q   <= '0;
      count_b_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= SETTLE;
            timer_q     <= SETTLE_LOAD;
            ro_enable_q <= 1'b1;
            ro_reset_q  <= 1'b0;
            busy_q      <= 1'b1;
            response_q  <= 1'b0;
            tie_q       <= 1'b0;
            count_a_q   <= '0;
            count_b_q   <= '0;
          end
        end
        SETTLE: begin
          // Oscillators run but their edges are not counted while they settle.
          if (timer_q == 16'd0) begin
            state_q <= COUNT;
            timer_q <= WINDOW_LOAD;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        COUNT: begin
          count_a_q <= count_a_d;
          count_b_q <= count_b_d;
          if (timer_q == 16'd0) begin
            state_q     <= COMPARE;
            ro_enable_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        COMPARE: begin
          response_q <= (count_a_q > count_b_q);
          tie_q      <= (count_a_q == count_b_q);
          state_q    <= DONE;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
        end
        DONE: begin
          state_q    <= IDLE;
          ro_reset_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          ro_enable_q <= 1'b0;
          ro_reset_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign ro_enable = ro_enable_q;
  assign ro_reset  = ro_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign response  = response_q;
  assign tie       = tie_q;
  assign count_a   = count_a_q;
  assign count_b   = count_b_q;

endmodule

// File: tb/tb_ro_puf_counter.sv
// Directed bench for ro_puf_counter: edge counting, comparison, saturation, reset and start handling.
// Expected results are queued when a measurement is launched and checked when done pulses.
// Every wait on the DUT is bounded by a cycle budget.
module tb_ro_puf_counter;

  localparam int TIMEOUT = 400;
  localparam int LAT     = 70;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        ro_a, ro_b;
  logic        ro_enable, ro_reset, busy, done, response, tie;
  logic [15:0] count_a, count_b;

  logic        ro_a4, ro_b4;
  logic        ro_enable4, ro_reset4, busy4, done4, response4, tie4;
  logic [3:0]  count_a4, count_b4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   a_lo;
    int   a_hi;
    int   b_lo;
    int   b_hi;
    logic resp;
    logic tie;
  } exp_t;

  exp_t sb[$];

  int per_a, per_b;
  bit lock;
  int ca, cb;

  always #5 clk = ~clk;

  ro_puf_counter #(.CNT_W(16), .WINDOW_CYCLES(64), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .ro_a(ro_a), .ro_b(ro_b),
    .ro_enable(ro_enable), .ro_reset(ro_reset), .busy(busy), .done(done),
    .response(response), .tie(tie), .count_a(count_a), .count_b(count_b)
  );

  ro_puf_counter #(.CNT_W(4), .WINDOW_CYCLES(64), .SETTLE_CYCLES(4)) u_sat (
    .clk(clk), .reset(reset), .start(start), .ro_a(ro_a4), .ro_b(ro_b4),
    .ro_enable(ro_enable4), .ro_reset(ro_reset4), .busy(busy4), .done(done4),
    .response(response4), .tie(tie4), .count_a(count_a4), .count_b(count_b4)
  );

  // Oscillator models: toggle every per_x clk cycles; ro_a4 toggles every cycle.
  initial begin
    ro_a = 1'b0; ro_b = 1'b0; ro_a4 = 1'b0; ro_b4 = 1'b0;
    ca = 0; cb = 0;
    forever begin
      @(negedge clk);
      ca++; cb++;
      if (ca >= per_a) begin ro_a = ~ro_a; ca = 0; end
      if (lock) ro_b = ro_a;
      else if (cb >= per_b) begin ro_b = ~ro_b; cb = 0; end
      ro_a4 = ~ro_a4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_rng({tag, "_count_a"}, count_a, e.a_lo, e.a_hi);
      chk_rng({tag, "_count_b"}, count_b, e.b_lo, e.b_hi);
      chk({tag, "_response"}, response, e.resp);
      chk({tag, "_tie"}, tie, e.tie);
    end
  endtask

  task automatic push_exp(input int a_lo, input int a_hi, input int b_lo, input int b_hi,
                          input logic resp, input logic t);
    exp_t e;
    e.a_lo = a_lo; e.a_hi = a_hi; e.b_lo = b_lo; e.b_hi = b_hi;
    e.resp = resp; e.tie = t;
    sb.push_back(e);
  endtask

  // Raises start at a negedge and waits for done; latency counts posedges from the start sample.
  task automatic measure(input string tag, input bit hold, input bit probe, input int exp_lat);
    int n;
    bit seen;
    n = 0; seen = 0;
    start = 1'b1;
    while (!seen && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      if (!hold) start = 1'b0;
      if (probe && n == 1) begin
        chk({tag, "_settle_busy"}, busy, 1);
        chk({tag, "_settle_enable"}, ro_enable, 1);
        chk({tag, "_settle_roreset"}, ro_reset, 0);
        chk({tag, "_start_clr_a"}, count_a, 0);
        chk({tag, "_start_clr_b"}, count_b, 0);
        chk({tag, "_start_clr_resp"}, response, 0);
      end
      if (probe && n == exp_lat - 1) begin
        chk({tag, "_compare_enable"}, ro_enable, 0);
        chk({tag, "_compare_busy"}, busy, 1);
      end
      if (done) seen = 1;
    end
    chk({tag, "_latency"}, n, exp_lat);
    if (seen) begin
      chk({tag, "_done_busy"}, busy, 0);
      chk({tag, "_done_enable"}, ro_enable, 0);
      sb_check(tag);
    end
  endtask

  initial begin
    int ndone, first_i;
    per_a = 4; per_b = 6; lock = 0;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_ro_reset", ro_reset, 1);
    chk("rst_ro_enable", ro_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_response", response, 0);
    chk("rst_tie", tie, 0);
    chk("rst_count_a", count_a, 0);
    chk("rst_count_b", count_b, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // A faster than B
    push_exp(7, 9, 4, 6, 1'b1, 1'b0);
    measure("a_fast", 0, 1, LAT);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_ro_reset", ro_reset, 1);
    chk("sat_count_a", count_a4, 15);
    chk("sat_count_b", count_b4, 0);
    chk("sat_response", response4, 1);
    repeat (3) @(negedge clk);

    // B faster than A
    per_a = 6; per_b = 4;
    push_exp(4, 6, 7, 9, 1'b0, 1'b0);
    measure("b_fast", 0, 1, LAT);
    repeat (3) @(negedge clk);

    // Phase-locked identical oscillators
    per_a = 4; lock = 1;
    push_exp(7, 9, 7, 9, 1'b0, 1'b1);
    measure("locked", 0, 1, LAT);
    chk("locked_equal", (count_a == count_b), 1);
    lock = 0; per_a = 4; per_b = 6;
    repeat (3) @(negedge clk);

    // Second start while busy must be dropped
    push_exp(7, 9, 4, 6, 1'b1, 1'b0);
    ndone = 0; first_i = 0;
    start = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = (i == 10 || i == 40) ? 1'b1 : 1'b0;
      if (done) begin
        ndone++;
        if (first_i == 0) first_i = i;
        sb_check("busy_ign");
      end
    end
    chk("busy_ign_ndone", ndone, 1);
    chk("busy_ign_latency", first_i, LAT);

    // Start held high re-triggers one cycle after done
    push_exp(7, 9, 4, 6, 1'b1, 1'b0);
    push_exp(7, 9, 4, 6, 1'b1, 1'b0);
    measure("held_1", 1, 0, LAT);
    measure("held_2", 1, 0, LAT + 1);
    start = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in cycle 20 of COUNT, with start also high (reset wins)
    start = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_count_nz", (count_a != 0), 1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("midrst_ro_reset", ro_reset, 1);
    chk("midrst_ro_enable", ro_enable, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_response", response, 0);
    chk("midrst_tie", tie, 0);
    chk("midrst_count_a", count_a, 0);
    chk("midrst_count_b", count_b, 0);
    @(negedge clk);
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_enable", ro_enable, 0);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(7, 9, 4, 6, 1'b1, 1'b0);
    measure("post_rst", 0, 1, LAT);
    repeat (3) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_puf_counter.md
RO_PUF_COUNTER -- requirements
Module: ro_puf_counter

Interface
REQ-001 Parameter CNT_W, default 16, width of each edge counter.
REQ-002 Parameter WINDOW_CYCLES, default 1024, length of the counting window in clk cycles (range 1..65535).
REQ-003 Parameter SETTLE_CYCLES, default 4, clk cycles between oscillator enable and counting start (range 1..255).
REQ-004 Port: clk, input, 1, system clock; all logic on its rising edge.
REQ-005 Port: reset, input, 1, synchronous, active-high; one clock; reset is synchronous and active-high.
REQ-006 Port: start, input, 1, request one measurement; sampled only in IDLE.
REQ-007 Port: ro_a, input, 1, divided ring-oscillator output A (dffout); asynchronous to clk.
REQ-008 Port: ro_b, input, 1, divided ring-oscillator output B (dffout); asynchronous to clk.
REQ-009 Port: ro_enable, output, 1, drives enable of both ring oscillators.
REQ-010 Port: ro_reset, output, 1, drives reset of both ring oscillators.
REQ-011 Port: busy, output, 1, high from the cycle after start is accepted until done.
REQ-012 Port: done, output, 1, one-cycle pulse when response is valid.
REQ-013 Port: response, output, 1, PUF bit, 1 when count_a > count_b.
REQ-014 Port: tie, output, 1, high when count_a == count_b.
REQ-015 Port: count_a / count_b, output, CNT_W each, final edge counts, held until next start.

Function
REQ-016 ro_a and ro_b SHALL each pass through a 2-flop synchronizer plus one history flop; a rising edge is sync==1 and history==0.
REQ-017 The FSM SHALL have states IDLE, SETTLE, COUNT, COMPARE, DONE.
- IDLE: ro_reset=1, ro_enable=0, busy=0.
- SETTLE: ro_reset=0, ro_enable=1, busy=1.
- COUNT, COMPARE, DONE: ro_enable=1 in COUNT only, 0 in COMPARE and DONE.
REQ-018 IDLE -> SETTLE on the cycle start==1 is sampled. On that same edge, count_a, count_b, response, and tie SHALL clear to 0.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to COUNT. No edges are counted in SETTLE.
REQ-020 COUNT SHALL last exactly WINDOW_CYCLES cycles. Each detected rising edge in COUNT increments its counter by 1.
REQ-021 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 COMPARE SHALL last 1 cycle and register response = (count_a > count_b) and tie = (count_a == count_b), unsigned.
REQ-023 DONE SHALL last 1 cycle with done=1, then return to IDLE. busy SHALL drop in the same cycle done is high.
REQ-024 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 A start held high continuously SHALL begin a new measurement on each return to IDLE, i.e. one cycle after done.
REQ-026 Total latency from the start-sample edge to the done pulse SHALL be SETTLE_CYCLES + WINDOW_CYCLES + 2 cycles.
REQ-027 Simultaneous edges on A and B in the same cycle SHALL increment both counters.

Reset
REQ-028 When reset is sampled high, in any state including mid-COUNT, the block SHALL return to IDLE on that edge.
REQ-029 Reset values SHALL be: ro_reset=1, ro_enable=0, busy=0, done=0, response=0, tie=0, count_a=0, count_b=0, all synchronizer and history flops 0.
REQ-030 reset SHALL have priority over start in the same cycle.

Verification
REQ-031 WINDOW_CYCLES=64, SETTLE_CYCLES=4; ro_a toggles every 4 clk (8-clk period), ro_b every 6 clk (12-clk period); pulse start -> count_a=8±1, count_b=5±1, response=1, tie=0, done exactly 70 cycles after the start edge.
REQ-032 Swap the ro_a and ro_b stimulus from REQ-031 -> response=0, tie=0.
REQ-033 ro_a and ro_b driven identically, phase-locked -> count_a==count_b, tie=1, response=0.
REQ-034 CNT_W=4; ro_a toggles every clk for the full 64-cycle window -> count_a saturates at 15 and does not wrap.
REQ-035 Assert reset at cycle 20 of COUNT -> next cycle in IDLE with all outputs at reset values and ro_enable=0. A subsequent start produces a fresh, correct result.
REQ-036 Pulse start again while busy -> ignored; exactly one done pulse is produced.
